// File: rtl/id_ex_pipe.sv
// Decode-to-execute pipeline register with load-use / branch-operand interlock
// and saturating stall/flush event counters.
module id_ex_pipe #(
   parameter int DATA_BITS     = 32,
   parameter int REG_ADDR_BITS = 5,
   parameter int CNT_BITS      = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     valid_d,
   input  logic                     reg_write_d,
   input  logic [1:0]               mem_to_reg_d,
   input  logic                     mem_write_d,
   input  logic [1:0]               alu_control_d,
   input  logic                     alu_src_d,
   input  logic [1:0]               reg_dst_d,
   input  logic [DATA_BITS-1:0]     rd1_d,
   input  logic [DATA_BITS-1:0]     rd2_d,
   input  logic [DATA_BITS-1:0]     sign_imm_d,
   input  logic [DATA_BITS-1:0]     pc_plus4_d,
   input  logic [REG_ADDR_BITS-1:0] rs_d,
   input  logic [REG_ADDR_BITS-1:0] rt_d,
   input  logic [REG_ADDR_BITS-1:0] rd_d,
   input  logic                     branch_d,
   input  logic                     reg_write_m,
   input  logic [1:0]               mem_to_reg_m,
   input  logic [REG_ADDR_BITS-1:0] write_reg_m,
   input  logic                     flush_e,
   output logic                     valid_e,
   output logic                     reg_write_e,
   output logic                     mem_write_e,
   output logic                     alu_src_e,
   output logic [1:0]               mem_to_reg_e,
   output logic [1:0]               alu_control_e,
   output logic [1:0]               reg_dst_e,
   output logic [DATA_BITS-1:0]     rd1_e,
   output logic [DATA_BITS-1:0]     rd2_e,
   output logic [DATA_BITS-1:0]     sign_imm_e,
   output logic [DATA_BITS-1:0]     pc_plus4_e,
   output logic [REG_ADDR_BITS-1:0] rs_e,
   output logic [REG_ADDR_BITS-1:0] rt_e,
   output logic [REG_ADDR_BITS-1:0] rd_e,
   output logic [REG_ADDR_BITS-1:0] write_reg_e,
   output logic                     stall_f,
   output logic                     stall_d,
   output logic [CNT_BITS-1:0]      stall_cnt,
   output logic [CNT_BITS-1:0]      flush_cnt
);

   localparam logic [REG_ADDR_BITS-1:0] REG_ZERO = '0;
   localparam logic [REG_ADDR_BITS-1:0] REG_RA   = REG_ADDR_BITS'(31);
   localparam logic [1:0]               SEL_MEM  = 2'b01;

   function automatic logic [CNT_BITS-1:0] sat_inc(input logic [CNT_BITS-1:0] v);
      return (&v) ? v : v + {{(CNT_BITS-1){1'b0}}, 1'b1};
   endfunction

   logic e_hit_d;
   logic m_hit_d;
   logic lw_stall;
   logic br_stall;
   logic stall;
   logic bubble;

   // Execute-stage destination decode; 11 means the instruction writes nothing.
   always_comb begin
      write_reg_e = REG_ZERO;
      case (reg_dst_e)
         2'b00:   write_reg_e = rt_e;
         2'b01:   write_reg_e = rd_e;
         2'b10:   write_reg_e = REG_RA;
         default: write_reg_e = REG_ZERO;
      endcase
   end

   // Hazard detection against the producer in E and a load in M
   always_comb begin
      e_hit_d  = valid_e && reg_write_e && (write_reg_e != REG_ZERO) &&
                 ((write_reg_e == rs_d) || (write_reg_e == rt_d));
      m_hit_d  = reg_write_m && (mem_to_reg_m == SEL_MEM) && (write_reg_m != REG_ZERO) &&
                 ((write_reg_m == rs_d) || (write_reg_m == rt_d));
      lw_stall = valid_d && e_hit_d && (mem_to_reg_e == SEL_MEM);
      br_stall = valid_d && branch_d && (e_hit_d || m_hit_d);
      stall    = !rst && (lw_stall || br_stall);
      bubble   = flush_e || stall;
      stall_f  = stall;
      stall_d  = stall;
   end

   // D -> E register boundary
   always_ff @(posedge clk) begin
      if (rst || bubble) begin
         valid_e       <= 1'b0;
         reg_write_e   <= 1'b0;
         mem_to_reg_e  <= '0;
         mem_write_e   <= 1'b0;
         alu_control_e <= '0;
         alu_src_e     <= 1'b0;
         reg_dst_e     <= '0;
         rd1_e         <= '0;
         rd2_e         <= '0;
         sign_imm_e    <= '0;
         pc_plus4_e    <= '0;
         rs_e          <= '0;
         rt_e          <= '0;
         rd_e          <= '0;
      end else begin
         valid_e       <= valid_d;
         reg_write_e   <= reg_write_d;
         mem_to_reg_e  <= mem_to_reg_d;
         mem_write_e   <= mem_write_d;
         alu_control_e <= alu_control_d;
         alu_src_e     <= alu_src_d;
         reg_dst_e     <= reg_dst_d;
         rd1_e         <= rd1_d;
         rd2_e         <= rd2_d;
         sign_imm_e    <= sign_imm_d;
         pc_plus4_e    <= pc_plus4_d;
         rs_e          <= rs_d;
         rt_e          <= rt_d;
         rd_e          <= rd_d;
      end
   end

   // Event counters: a flushed cycle is charged to flush only, even if it also stalls
   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else if (flush_e) begin
         flush_cnt <= sat_inc(flush_cnt);
      end else if (stall) begin
         stall_cnt <= sat_inc(stall_cnt);
      end
   end

endmodule

// File: tb/tb_id_ex_pipe.sv
// Scoreboard bench for id_ex_pipe: per-cycle hazard expectations, queued E-stage results.
module tb_id_ex_pipe;

   localparam int CW = 4;

   typedef struct packed {
      logic        valid;
      logic        reg_write;
      logic [1:0]  mem_to_reg;
      logic        mem_write;
      logic [1:0]  alu_control;
      logic        alu_src;
      logic [1:0]  reg_dst;
      logic [31:0] rd1;
      logic [31:0] rd2;
      logic [31:0] sign_imm;
      logic [31:0] pc_plus4;
      logic [4:0]  rs;
      logic [4:0]  rt;
      logic [4:0]  rd;
   } bundle_t;

   logic clk = 1'b0;
   logic rst;
   logic valid_d, reg_write_d, mem_write_d, alu_src_d, branch_d;
   logic [1:0] mem_to_reg_d, alu_control_d, reg_dst_d;
   logic [31:0] rd1_d, rd2_d, sign_imm_d, pc_plus4_d;
   logic [4:0] rs_d, rt_d, rd_d;
   logic reg_write_m, flush_e;
   logic [1:0] mem_to_reg_m;
   logic [4:0] write_reg_m;
   logic valid_e, reg_write_e, mem_write_e, alu_src_e;
   logic [1:0] mem_to_reg_e, alu_control_e, reg_dst_e;
   logic [31:0] rd1_e, rd2_e, sign_imm_e, pc_plus4_e;
   logic [4:0] rs_e, rt_e, rd_e, write_reg_e;
   logic stall_f, stall_d;
   logic [CW-1:0] stall_cnt, flush_cnt;

   int n_vec = 0;
   int n_err = 0;
   bundle_t exp_q[$];
   logic [CW-1:0] exp_stall_cnt = '0;
   logic [CW-1:0] exp_flush_cnt = '0;

   always #5 clk = ~clk;

   id_ex_pipe #(.DATA_BITS(32), .REG_ADDR_BITS(5), .CNT_BITS(CW)) dut (
      .clk(clk), .rst(rst), .valid_d(valid_d), .reg_write_d(reg_write_d),
      .mem_to_reg_d(mem_to_reg_d), .mem_write_d(mem_write_d), .alu_control_d(alu_control_d),
      .alu_src_d(alu_src_d), .reg_dst_d(reg_dst_d), .rd1_d(rd1_d), .rd2_d(rd2_d),
      .sign_imm_d(sign_imm_d), .pc_plus4_d(pc_plus4_d), .rs_d(rs_d), .rt_d(rt_d), .rd_d(rd_d),
      .branch_d(branch_d), .reg_write_m(reg_write_m), .mem_to_reg_m(mem_to_reg_m),
      .write_reg_m(write_reg_m), .flush_e(flush_e), .valid_e(valid_e),
      .reg_write_e(reg_write_e), .mem_write_e(mem_write_e), .alu_src_e(alu_src_e),
      .mem_to_reg_e(mem_to_reg_e), .alu_control_e(alu_control_e), .reg_dst_e(reg_dst_e),
      .rd1_e(rd1_e), .rd2_e(rd2_e), .sign_imm_e(sign_imm_e), .pc_plus4_e(pc_plus4_e),
      .rs_e(rs_e), .rt_e(rt_e), .rd_e(rd_e), .write_reg_e(write_reg_e),
      .stall_f(stall_f), .stall_d(stall_d), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
   );

   task automatic check(input string tag, input logic [159:0] obs, input logic [159:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic bundle_t mk(input logic v, input logic rw, input logic [1:0] m2r,
                                  input logic [1:0] dst, input logic [4:0] rs,
                                  input logic [4:0] rt, input logic [4:0] rd);
      bundle_t b;
      b.valid       = v;
      b.reg_write   = rw;
      b.mem_to_reg  = m2r;
      b.mem_write   = 1'($urandom);
      b.alu_control = 2'($urandom);
      b.alu_src     = 1'($urandom);
      b.reg_dst     = dst;
      b.rd1         = $urandom;
      b.rd2         = $urandom;
      b.sign_imm    = $urandom;
      b.pc_plus4    = $urandom;
      b.rs          = rs;
      b.rt          = rt;
      b.rd          = rd;
      return b;
   endfunction

   function automatic logic [4:0] exp_wr(input bundle_t b);
      case (b.reg_dst)
         2'b00:   return b.rt;
         2'b01:   return b.rd;
         2'b10:   return 5'd31;
         default: return 5'd0;
      endcase
   endfunction

   function automatic logic [CW-1:0] sat(input logic [CW-1:0] v);
      return (v == {CW{1'b1}}) ? v : v + 1'b1;
   endfunction

   // One clock: drive decode/M inputs, check the interlock, then the registered E state.
   task automatic step(input logic r, input bundle_t d, input logic br, input logic rw_m,
                       input logic [1:0] m2r_m, input logic [4:0] wr_m, input logic fl,
                       input logic exp_stall);
      bundle_t got;
      bundle_t obs;
      rst = r;
      valid_d = d.valid; reg_write_d = d.reg_write; mem_to_reg_d = d.mem_to_reg;
      mem_write_d = d.mem_write; alu_control_d = d.alu_control; alu_src_d = d.alu_src;
      reg_dst_d = d.reg_dst; rd1_d = d.rd1; rd2_d = d.rd2; sign_imm_d = d.sign_imm;
      pc_plus4_d = d.pc_plus4; rs_d = d.rs; rt_d = d.rt; rd_d = d.rd; branch_d = br;
      reg_write_m = rw_m; mem_to_reg_m = m2r_m; write_reg_m = wr_m; flush_e = fl;
      #1;
      check("stall_f", 160'(stall_f), 160'(exp_stall));
      check("stall_d", 160'(stall_d), 160'(exp_stall));
      exp_q.push_back((r || fl || exp_stall) ? bundle_t'(0) : d);
      if (r) begin
         exp_stall_cnt = '0;
         exp_flush_cnt = '0;
      end else if (fl) begin
         exp_flush_cnt = sat(exp_flush_cnt);
      end else if (exp_stall) begin
         exp_stall_cnt = sat(exp_stall_cnt);
      end
      @(posedge clk);
      #1;
      got = exp_q.pop_front();
      obs = '{valid_e, reg_write_e, mem_to_reg_e, mem_write_e, alu_control_e, alu_src_e,
              reg_dst_e, rd1_e, rd2_e, sign_imm_e, pc_plus4_e, rs_e, rt_e, rd_e};
      check("e_regs", 160'(obs), 160'(got));
      check("write_reg_e", 160'(write_reg_e), 160'(exp_wr(got)));
      check("stall_cnt", 160'(stall_cnt), 160'(exp_stall_cnt));
      check("flush_cnt", 160'(flush_cnt), 160'(exp_flush_cnt));
      @(negedge clk);
   endtask

   initial begin
      bundle_t add8, beq9, beq9t, add8f, br_sat;
      // Reset with random inputs, including random flush and M-stage activity
      for (int i = 0; i < 3; i++)
         step(1'b1, mk(1'($urandom), 1'($urandom), 2'($urandom), 2'($urandom),
                       5'($urandom), 5'($urandom), 5'($urandom)),
              1'($urandom), 1'($urandom), 2'($urandom), 5'($urandom), 1'($urandom), 1'b0);

      // Load-use: lw r8 then add using r8
      step(1'b0, mk(1, 1, 2'b01, 2'b00, 5'd3, 5'd8, 5'd0), 0, 0, 2'b00, 5'd0, 0, 0);
      add8 = mk(1, 1, 2'b00, 2'b01, 5'd8, 5'd4, 5'd10);
      step(1'b0, add8, 0, 0, 2'b00, 5'd0, 0, 1);
      step(1'b0, add8, 0, 0, 2'b00, 5'd0, 0, 0);
      check("lu_stall_cnt", 160'(stall_cnt), 160'(1));

      // Branch after ALU producer: 1-cycle stall
      step(1'b0, mk(1, 1, 2'b00, 2'b01, 5'd1, 5'd2, 5'd9), 0, 0, 2'b00, 5'd0, 0, 0);
      beq9 = mk(1, 0, 2'b00, 2'b00, 5'd9, 5'd5, 5'd0);
      step(1'b0, beq9, 1, 0, 2'b00, 5'd0, 0, 1);
      step(1'b0, beq9, 1, 0, 2'b00, 5'd0, 0, 0);

      // Branch after load: stall with lw in E, then again with lw in M
      step(1'b0, mk(1, 1, 2'b01, 2'b00, 5'd2, 5'd9, 5'd0), 0, 0, 2'b00, 5'd0, 0, 0);
      beq9t = mk(1, 0, 2'b00, 2'b00, 5'd1, 5'd9, 5'd0);
      step(1'b0, beq9t, 1, 0, 2'b00, 5'd0, 0, 1);
      step(1'b0, beq9t, 1, 1, 2'b01, 5'd9, 0, 1);
      step(1'b0, beq9t, 1, 0, 2'b00, 5'd0, 0, 0);
      check("br_stall_cnt", 160'(stall_cnt), 160'(4));

      // r0 destination never interlocks; the add also exercises reg_dst=11
      step(1'b0, mk(1, 1, 2'b01, 2'b00, 5'd5, 5'd0, 5'd0), 0, 0, 2'b00, 5'd0, 0, 0);
      step(1'b0, mk(1, 1, 2'b00, 2'b11, 5'd0, 5'd0, 5'd11), 0, 0, 2'b00, 5'd0, 0, 0);

      // Flush coinciding with a load-use stall, then flush alone
      step(1'b0, mk(1, 1, 2'b01, 2'b00, 5'd1, 5'd8, 5'd0), 0, 0, 2'b00, 5'd0, 0, 0);
      add8f = mk(1, 1, 2'b00, 2'b01, 5'd8, 5'd3, 5'd12);
      step(1'b0, add8f, 0, 0, 2'b00, 5'd0, 1, 1);
      check("fl_flush_cnt", 160'(flush_cnt), 160'(1));
      check("fl_stall_cnt", 160'(stall_cnt), 160'(4));
      step(1'b0, add8f, 0, 0, 2'b00, 5'd0, 0, 0);
      step(1'b0, mk(1, 1, 2'b00, 2'b10, 5'd1, 5'd2, 5'd13), 0, 0, 2'b00, 5'd0, 1, 0);

      // jal-style r31 destination
      step(1'b0, mk(1, 1, 2'b10, 2'b10, 5'd0, 5'd0, 5'd0), 0, 0, 2'b00, 5'd0, 0, 0);

      // Held branch against a load in M: stall_cnt must saturate
      br_sat = mk(1, 0, 2'b00, 2'b00, 5'd9, 5'd4, 5'd0);
      for (int i = 0; i < 20; i++)
         step(1'b0, br_sat, 1, 1, 2'b01, 5'd9, 0, 1);
      check("stall_sat", 160'(stall_cnt), 160'(15));

      // Same hazard pattern with valid_d=0 does not stall
      step(1'b0, mk(0, 0, 2'b00, 2'b00, 5'd9, 5'd4, 5'd0), 1, 1, 2'b01, 5'd9, 0, 0);

      // Flush counter saturation
      for (int i = 0; i < 20; i++)
         step(1'b0, mk(0, 0, 2'b00, 2'b00, 5'd0, 5'd0, 5'd0), 0, 0, 2'b00, 5'd0, 1, 0);
      check("flush_sat", 160'(flush_cnt), 160'(15));

      // Reset arriving during a load-use stall
      step(1'b0, mk(1, 1, 2'b01, 2'b00, 5'd1, 5'd8, 5'd0), 0, 0, 2'b00, 5'd0, 0, 0);
      add8 = mk(1, 1, 2'b00, 2'b01, 5'd8, 5'd4, 5'd10);
      step(1'b1, add8, 0, 0, 2'b00, 5'd0, 0, 0);
      step(1'b0, add8, 0, 0, 2'b00, 5'd0, 0, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/id_ex_pipe.md
Name: id_ex_pipe

Overview:
- Decode-to-execute pipeline register and interlock for the 5-stage MIPS pipeline.
- Captures the decode-stage control bundle and operands into the execute stage.
- Detects load-use and branch-operand hazards, drives the fetch/decode stall signals, and inserts bubbles.
- Keeps saturating stall and flush event counters for performance debug.

Parameters:
- DATA_BITS, 32, operand / immediate / PC width
- REG_ADDR_BITS, 5, register specifier width
- CNT_BITS, 16, width of each event counter

Ports:
- clk  in  1  pipeline clock
- rst  in  1  synchronous active-high reset
- valid_d  in  1  decode slot holds a real instruction
- reg_write_d  in  1  decode control bit
- mem_to_reg_d  in  2  decode control: 00 ALU, 01 memory, 10 PC+4
- mem_write_d  in  1  decode control bit
- alu_control_d  in  2  decode control field
- alu_src_d  in  1  decode control bit
- reg_dst_d  in  2  decode control: 00 rt, 01 rd, 10 r31
- rd1_d, rd2_d, sign_imm_d, pc_plus4_d  in  DATA_BITS each  decode operands
- rs_d, rt_d, rd_d  in  REG_ADDR_BITS each  decode register specifiers
- branch_d  in  1  decode instruction is a branch (compares in decode)
- reg_write_m  in  1  memory-stage write enable
- mem_to_reg_m  in  2  memory-stage result select
- write_reg_m  in  REG_ADDR_BITS  memory-stage destination
- flush_e  in  1  kill the instruction entering execute
- valid_e, reg_write_e, mem_write_e, alu_src_e  out  1 each  registered execute copies
- mem_to_reg_e, alu_control_e, reg_dst_e  out  2 each  registered execute copies
- rd1_e, rd2_e, sign_imm_e, pc_plus4_e  out  DATA_BITS each  registered execute copies
- rs_e, rt_e, rd_e  out  REG_ADDR_BITS each  registered execute copies
- write_reg_e  out  REG_ADDR_BITS  combinational destination select from reg_dst_e
- stall_f, stall_d  out  1 each  hold the PC and IF/ID registers
- stall_cnt, flush_cnt  out  CNT_BITS each  saturating event counters

Behaviour:
- Reset (rst=1 at a clk edge): every _e output is 0; stall_cnt and flush_cnt are 0.
- Reset mid-stall: the stall deasserts the cycle after, because its sources (valid_e) are now 0.
- write_reg_e (combinational):
  - reg_dst_e 00 gives rt_e; 01 gives rd_e; 10 gives 31.
  - reg_dst_e 11 gives 0, which means no write.
- lw_stall (combinational):
  - valid_d & valid_e & reg_write_e & mem_to_reg_e==01
  - & write_reg_e!=0 & (write_reg_e==rs_d | write_reg_e==rt_d).
- br_stall (combinational): valid_d & branch_d & (A | B).
  - A: valid_e & reg_write_e & write_reg_e!=0 & write_reg_e matches rs_d or rt_d.
  - B: reg_write_m & mem_to_reg_m==01 & write_reg_m!=0 & write_reg_m matches rs_d or rt_d.
- stall = lw_stall | br_stall.
  - stall_f = stall_d = stall, combinational, same cycle.
  - stall is forced to 0 while rst=1.
- Register update priority at each clk edge: rst > flush_e > stall > load.
  - flush_e or stall: insert a bubble. All _e control and data fields become 0 and valid_e=0.
  - Otherwise: load every _d field into _e, with valid_e=valid_d.
- Latency: exactly 1 cycle from D to E when no stall or flush.
- Decode-side hold: during a stall the decode inputs are held upstream. The same instruction re-evaluates the next cycle and loads once the hazard clears.
  - A load-use stall therefore lasts exactly 1 cycle.
  - A branch stall lasts 1 or 2 cycles (ALU producer in E, then load in M).
- stall_cnt: +1 on every cycle with stall=1 and flush_e=0; saturates at all-ones.
- flush_cnt: +1 on every cycle with flush_e=1; saturates at all-ones.
- flush_e and stall together: bubble inserted; only flush_cnt increments; stall_f/stall_d still assert.
- Register 0 never causes a hazard.
- valid_d=0 never causes a stall.

Test Plan:
- Reset held 3 cycles with random inputs -> all _e outputs and both counters are 0; stall_f=0.
- Load-use:
  - Stimulus: lw r8 in E (reg_write_e=1, mem_to_reg_e=01, reg_dst_e=00, rt_e=8), then add with rs_d=8.
  - Response: stall_f=stall_d=1 for 1 cycle; bubble (valid_e=0) in E; add enters E next cycle; stall_cnt=1.
- Branch after ALU op:
  - Stimulus: add r9 in E (reg_dst_e=01, rd_e=9), then beq with rs_d=9.
  - Response: 1-cycle stall.
  - Variant: lw r9 in E, then beq rt_d=9 -> 2-cycle stall (E then M case); stall_cnt=2.
- r0 destination: lw with rt_e=0 and add rs_d=0 -> no stall; add loads in 1 cycle.
- Flush during stall: lw-use stall with flush_e=1 in the same cycle -> bubble; flush_cnt=1; stall_cnt unchanged; flush_e alone with valid_d=1 -> valid_e=0 next cycle.
- Saturation: CNT_BITS=4, force stall for 20 cycles -> stall_cnt sticks at 15 and does not wrap.
